// File: rtl/bstx_pkg.sv
// bit_stream_tx shared types and defaults.
// Imported by the top and the shifter.
package bstx_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

endpackage

// File: rtl/bstx_shifter.sv
// Word shift register with bit index.
// Holds the not-yet-presented bits of the current word.
module bstx_shifter
  import bstx_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              next_bit,
  output logic              word_empty
);

  localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] sr;
  logic [IW-1:0]     idx;

  // bit 0 goes out straight from din on load, so keep din[W-1:1]
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      idx <= '0;
    end else if (en) begin
      if (load) begin
        sr  <= din >> 1;
        idx <= IW'(1);
      end else if (shift) begin
        sr  <= sr >> 1;
        idx <= (idx == IW'(WORD_W - 1)) ? '0 : idx + IW'(1);
      end
    end
  end

  assign next_bit   = sr[0];
  assign word_empty = (idx == '0);

endmodule

// File: rtl/bit_stream_tx.sv
// Serializes data words (or holds a mode) toward a controller.
// Each command ends with one GAP cycle and a done pulse.
module bit_stream_tx
  import bstx_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WORD_W-1:0] cmd_mode,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic              cmd_has_data,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  output logic [WORD_W-1:0] mode,
  output logic [WORD_W-1:0] in_data,
  output logic              dut_enable,
  output logic              busy,
  output logic              done
);

  state_t state, state_d;

  logic [WORD_W-1:0] lmode_q, lmode_d;
  logic [WORD_W-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bit_q, bit_d;
  logic              den_q, den_d;
  logic              done_q, done_d;

  logic sh_load, sh_shift, sh_bit, sh_empty;
  logic cnt_zero, cmd_fire, word_fire;

  assign cnt_zero = (cnt_q == '0);

  assign cmd_ready = enable & ~reset & ~done_q
                   & (state == S_IDLE);

  assign word_ready = enable & ~reset
                    & ((state == S_LOAD)
                    | ((state == S_SHIFT) & sh_empty & ~cnt_zero));

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign word_fire = word_valid & word_ready;

  // state register, frozen while enable is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       state <= S_IDLE;
    else if (enable) state <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0)     state_d = S_GAP;
          else if (cmd_has_data) state_d = S_LOAD;
          else                   state_d = S_HOLD;
        end
      end
      S_LOAD: begin
        if (word_fire) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_zero)                     state_d = S_GAP;
        else if (sh_empty && !word_valid) state_d = S_LOAD;
      end
      S_HOLD: begin
        if (cnt_q <= CNT_W'(1)) state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // next values of the registered outputs and datapath
  always_comb begin
    lmode_d  = lmode_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    den_d    = den_q;
    done_d   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    unique case (state)
      S_IDLE: begin
        mode_d = '0;
        bit_d  = 1'b0;
        den_d  = 1'b0;
        if (cmd_fire) begin
          lmode_d = cmd_mode;
          cnt_d   = cmd_len;
          if (cmd_len == '0) begin
            den_d = 1'b1;
          end else begin
            mode_d = cmd_mode;
            den_d  = !cmd_has_data;
          end
        end
      end
      S_LOAD: begin
        if (word_fire) begin
          sh_load = 1'b1;
          bit_d   = word_data[0];
          den_d   = 1'b1;
          mode_d  = lmode_q;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_zero) begin
          mode_d = '0;
          bit_d  = 1'b0;
          den_d  = 1'b1;
        end else if (sh_empty) begin
          if (word_valid) begin
            sh_load = 1'b1;
            bit_d   = word_data[0];
            cnt_d   = cnt_q - CNT_W'(1);
          end else begin
            den_d = 1'b0;
          end
        end else begin
          sh_shift = 1'b1;
          bit_d    = sh_bit;
          cnt_d    = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          mode_d = '0;
          bit_d  = 1'b0;
          den_d  = 1'b1;
        end
      end
      S_GAP: begin
        mode_d = '0;
        bit_d  = 1'b0;
        den_d  = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        mode_d = '0;
        bit_d  = 1'b0;
        den_d  = 1'b0;
      end
    endcase
  end

  // datapath and output registers, frozen while enable is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lmode_q <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      den_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (enable) begin
      lmode_q <= lmode_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      den_q   <= den_d;
      done_q  <= done_d;
    end
  end

  bstx_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .en         (enable),
    .load       (sh_load),
    .shift      (sh_shift),
    .din        (word_data),
    .next_bit   (sh_bit),
    .word_empty (sh_empty)
  );

  assign mode       = mode_q;
  assign in_data    = {{(WORD_W-1){1'b0}}, bit_q};
  assign dut_enable = den_q;
  assign busy       = (state != S_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_bit_stream_tx.sv
// Directed bench for bit_stream_tx.
// One task per scenario, inline checks.
module tb_bit_stream_tx;

  localparam int WW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic          cmd_valid, cmd_ready, cmd_has_data;
  logic [WW-1:0] cmd_mode, word_data, mode, in_data;
  logic [CW-1:0] cmd_len;
  logic          word_valid, word_ready;
  logic          dut_enable, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  logic          r_den  [0:255];
  logic [WW-1:0] r_mode [0:255];
  logic [WW-1:0] r_in   [0:255];
  logic          r_done [0:255];
  logic          r_cr   [0:255];
  int            r_n;
  logic          r_wr, r_extra;

  logic          e_den  [0:255];
  logic [WW-1:0] e_mode [0:255];
  logic [WW-1:0] e_in   [0:255];
  logic          e_done [0:255];
  int            e_n;

  logic [WW-1:0] wq [0:3];
  int            wq_n;
  int            w_delay;

  always #5 clk = ~clk;

  bit_stream_tx #(
    .WORD_W (WW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_len      (cmd_len),
    .cmd_has_data (cmd_has_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_data    (word_data),
    .mode         (mode),
    .in_data      (in_data),
    .dut_enable   (dut_enable),
    .busy         (busy),
    .done         (done)
  );

  function automatic void set_exp(int c, logic d, logic [WW-1:0] m,
                                  logic b, logic dn);
    e_den[c]  = d;
    e_mode[c] = m;
    e_in[c]   = {{(WW-1){1'b0}}, b};
    e_done[c] = dn;
  endfunction

  // issues one command, feeds words from wq, records each cycle
  task automatic run_stream(input logic [WW-1:0] m, input int len,
                            input logic hd);
    int wi = 0;
    int waited = 0;
    bit fired = 0;
    @(negedge clk);
    cmd_mode     = m;
    cmd_len      = len[CW-1:0];
    cmd_has_data = hd;
    cmd_valid    = 1'b1;
    word_valid   = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    r_n     = 0;
    r_wr    = 1'b0;
    r_extra = 1'b0;
    for (int c = 0; c < 256; c++) begin
      if (c > 0) @(negedge clk);
      if (fired) begin
        wi++;
        fired  = 0;
        waited = 0;
      end
      word_valid = 1'b0;
      if (word_ready) begin
        r_wr = 1'b1;
        if (wi >= wq_n) r_extra = 1'b1;
        else if (wi == 0 || waited >= w_delay) begin
          word_valid = 1'b1;
          word_data  = wq[wi];
          fired      = 1;
        end else waited++;
      end
      r_den[c]  = dut_enable;
      r_mode[c] = mode;
      r_in[c]   = in_data;
      r_done[c] = done;
      r_cr[c]   = cmd_ready;
      r_n       = c + 1;
      if (done) break;
    end
    word_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mode, in_data, dut_enable, busy, done, cmd_ready, word_ready}
        !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got mode=%h in=%h den=%b busy=%b done=%b cr=%b wr=%b want all 0",
               mode, in_data, dut_enable, busy, done, cmd_ready, word_ready);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release got cr=%b busy=%b want cr=1 busy=0",
               cmd_ready, busy);
    end
  endtask

  task automatic test_basic;
    wq[0] = 32'h5; wq_n = 1; w_delay = 0;
    run_stream(32'h182, 4, 1'b1);
    set_exp(0, 0, 32'h182, 0, 0);
    set_exp(1, 1, 32'h182, 1, 0);
    set_exp(2, 1, 32'h182, 0, 0);
    set_exp(3, 1, 32'h182, 1, 0);
    set_exp(4, 1, 32'h182, 0, 0);
    set_exp(5, 1, 32'h0, 0, 0);
    set_exp(6, 0, 32'h0, 0, 1);
    e_n = 7;
    n_cmp++;
    if (r_n !== e_n) begin
      n_bad++;
      $display("FAIL basic_len got %0d cycles want %0d", r_n, e_n);
    end
    for (int c = 0; c < e_n && c < r_n; c++) begin
      n_cmp++;
      if (r_den[c] !== e_den[c] || r_mode[c] !== e_mode[c] ||
          r_in[c] !== e_in[c] || r_done[c] !== e_done[c]) begin
        n_bad++;
        $display("FAIL basic c=%0d got den=%b mode=%h in=%h done=%b want den=%b mode=%h in=%h done=%b",
                 c, r_den[c], r_mode[c], r_in[c], r_done[c],
                 e_den[c], e_mode[c], e_in[c], e_done[c]);
      end
    end
    n_cmp++;
    if (r_cr[r_n-1] !== 1'b0 || r_extra !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_cycle got cr=%b extra=%b want 0 0",
               r_cr[r_n-1], r_extra);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_after_done got cr=%b done=%b want 1 0",
               cmd_ready, done);
    end
  endtask

  task automatic test_full_word;
    logic [WW-1:0] w;
    w = 32'h8000_0001;
    wq[0] = w; wq_n = 1; w_delay = 0;
    run_stream(32'h182, 32, 1'b1);
    set_exp(0, 0, 32'h182, 0, 0);
    for (int c = 1; c <= 32; c++) set_exp(c, 1, 32'h182, w[c-1], 0);
    set_exp(33, 1, 32'h0, 0, 0);
    set_exp(34, 0, 32'h0, 0, 1);
    e_n = 35;
    n_cmp++;
    if (r_n !== e_n || r_extra !== 1'b0) begin
      n_bad++;
      $display("FAIL full_word_len got %0d cycles extra=%b want %0d 0",
               r_n, r_extra, e_n);
    end
    for (int c = 0; c < e_n && c < r_n; c++) begin
      n_cmp++;
      if (r_den[c] !== e_den[c] || r_mode[c] !== e_mode[c] ||
          r_in[c] !== e_in[c] || r_done[c] !== e_done[c]) begin
        n_bad++;
        $display("FAIL full_word c=%0d got den=%b mode=%h in=%h done=%b want den=%b mode=%h in=%h done=%b",
                 c, r_den[c], r_mode[c], r_in[c], r_done[c],
                 e_den[c], e_mode[c], e_in[c], e_done[c]);
      end
    end
  endtask

  task automatic test_two_words(input int dly);
    logic [WW-1:0] w2;
    int k;
    w2 = 32'hAA;
    wq[0] = 32'hFFFF_FFFF; wq[1] = w2; wq_n = 2; w_delay = dly;
    run_stream(32'h182, 40, 1'b1);
    set_exp(0, 0, 32'h182, 0, 0);
    for (int c = 1; c <= 32; c++) set_exp(c, 1, 32'h182, 1, 0);
    for (int c = 33; c < 33 + dly; c++) set_exp(c, 0, 32'h182, 1, 0);
    for (int i = 0; i < 8; i++) set_exp(33 + dly + i, 1, 32'h182, w2[i], 0);
    k = 41 + dly;
    set_exp(k, 1, 32'h0, 0, 0);
    set_exp(k + 1, 0, 32'h0, 0, 1);
    e_n = k + 2;
    n_cmp++;
    if (r_n !== e_n || r_extra !== 1'b0) begin
      n_bad++;
      $display("FAIL two_words_len dly=%0d got %0d cycles extra=%b want %0d 0",
               dly, r_n, r_extra, e_n);
    end
    for (int c = 0; c < e_n && c < r_n; c++) begin
      n_cmp++;
      if (r_den[c] !== e_den[c] || r_mode[c] !== e_mode[c] ||
          r_in[c] !== e_in[c] || r_done[c] !== e_done[c]) begin
        n_bad++;
        $display("FAIL two_words dly=%0d c=%0d got den=%b mode=%h in=%h done=%b want den=%b mode=%h in=%h done=%b",
                 dly, c, r_den[c], r_mode[c], r_in[c], r_done[c],
                 e_den[c], e_mode[c], e_in[c], e_done[c]);
      end
    end
  endtask

  task automatic test_hold;
    wq_n = 0; w_delay = 0;
    run_stream(32'h0001_801, 96, 1'b0);
    for (int c = 0; c < 96; c++) set_exp(c, 1, 32'h1801, 0, 0);
    set_exp(96, 1, 32'h0, 0, 0);
    set_exp(97, 0, 32'h0, 0, 1);
    e_n = 98;
    n_cmp++;
    if (r_n !== e_n || r_wr !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_len got %0d cycles word_ready_seen=%b want %0d 0",
               r_n, r_wr, e_n);
    end
    for (int c = 0; c < e_n && c < r_n; c++) begin
      n_cmp++;
      if (r_den[c] !== e_den[c] || r_mode[c] !== e_mode[c] ||
          r_in[c] !== e_in[c] || r_done[c] !== e_done[c]) begin
        n_bad++;
        $display("FAIL hold c=%0d got den=%b mode=%h in=%h done=%b want den=%b mode=%h in=%h done=%b",
                 c, r_den[c], r_mode[c], r_in[c], r_done[c],
                 e_den[c], e_mode[c], e_in[c], e_done[c]);
      end
    end
  endtask

  task automatic test_zero_len;
    wq_n = 0; w_delay = 0;
    run_stream(32'h182, 0, 1'b1);
    n_cmp++;
    if (r_n !== 2 || r_den[0] !== 1'b1 || r_mode[0] !== '0 ||
        r_done[1] !== 1'b1 || r_den[1] !== 1'b0 || r_wr !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_len got n=%0d den0=%b mode0=%h done1=%b den1=%b wr=%b want 2 1 0 1 0 0",
               r_n, r_den[0], r_mode[0], r_done[1], r_den[1], r_wr);
    end
  endtask

  task automatic test_reset_mid;
    bit saw_done = 0;
    @(negedge clk);
    cmd_mode = 32'h182; cmd_len = 16'd32; cmd_has_data = 1'b1;
    cmd_valid = 1'b1;
    word_data = 32'h0000_0400; word_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    word_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (in_data !== 32'h1 || dut_enable !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_bit10 got in=%h den=%b busy=%b want 1 1 1",
               in_data, dut_enable, busy);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({mode, in_data, dut_enable, busy, done, cmd_ready, word_ready}
        !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_async got mode=%h in=%h den=%b busy=%b done=%b cr=%b wr=%b want all 0",
               mode, in_data, dut_enable, busy, done, cmd_ready, word_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_release got cr=%b busy=%b want 1 0",
               cmd_ready, busy);
    end
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_no_done got done_seen=%b want 0", saw_done);
    end
  endtask

  task automatic test_enable_freeze;
    logic [WW-1:0] w;
    w = 32'h0000_B2C5;
    @(negedge clk);
    cmd_mode = 32'h182; cmd_len = 16'd16; cmd_has_data = 1'b1;
    cmd_valid = 1'b1;
    word_data = w; word_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    word_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (in_data !== {31'b0, w[k]} || dut_enable !== 1'b1 ||
          mode !== 32'h182) begin
        n_bad++;
        $display("FAIL enable_bit k=%0d got in=%h den=%b mode=%h want in=%0d den=1 mode=182",
                 k, in_data, dut_enable, mode, w[k]);
      end
      if (k == 5) begin
        enable = 1'b0;
        for (int f = 0; f < 5; f++) begin
          @(negedge clk);
          n_cmp++;
          if (in_data !== {31'b0, w[5]} || dut_enable !== 1'b1 ||
              mode !== 32'h182 || busy !== 1'b1 ||
              cmd_ready !== 1'b0 || word_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL enable_frozen f=%0d got in=%h den=%b mode=%h busy=%b cr=%b wr=%b want %0d 1 182 1 0 0",
                     f, in_data, dut_enable, mode, busy, cmd_ready,
                     word_ready, w[5]);
          end
        end
        enable = 1'b1;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (mode !== '0 || dut_enable !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL enable_gap got mode=%h den=%b done=%b want 0 1 0",
               mode, dut_enable, done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || dut_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL enable_done got done=%b den=%b want 1 0",
               done, dut_enable);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    cmd_valid = 1'b0; cmd_mode = '0; cmd_len = '0; cmd_has_data = 1'b0;
    word_valid = 1'b0; word_data = '0;
    wq_n = 0; w_delay = 0; e_n = 0; r_n = 0;
    r_wr = 1'b0; r_extra = 1'b0;
    test_reset;
    test_basic;
    test_full_word;
    test_two_words(0);
    test_two_words(3);
    test_hold;
    test_zero_len;
    test_reset_mid;
    test_enable_freeze;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
